// File: rtl/app_switch_pkg.sv
// rtl/app_switch_pkg.sv - shared types and blanked-output constants for the channel switch controller
package app_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    localparam logic [3:0] BLANK_FND_COM = 4'hF;
    localparam logic [7:0] BLANK_FND     = 8'hFF;
    localparam logic       BLANK_TX      = 1'b1;

    // NONE is encoded as the channel count, one past the last valid id
    function automatic int id_none(input int n_ch);
        return n_ch;
    endfunction

    function automatic int id_width(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/app_switch_ctrl_if.sv
// rtl/app_switch_ctrl_if.sv - channel-side inputs and muxed outputs of the switch controller
interface app_switch_ctrl_if #(
    parameter int N_CH  = 3,
    parameter int LED_W = 5
);
    localparam int ID_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]       sw;
    logic [4*N_CH-1:0]     ch_fnd_com;
    logic [8*N_CH-1:0]     ch_fnd;
    logic [LED_W*N_CH-1:0] ch_led;
    logic [N_CH-1:0]       ch_tx;
    logic [N_CH-1:0]       ch_tx_busy;
    logic [N_CH-1:0]       enable;
    logic [3:0]            fnd_com;
    logic [7:0]            fnd;
    logic [LED_W-1:0]      led;
    logic                  tx;
    logic [ID_W-1:0]       active_id;
    logic                  switching;

    modport master (
        output sw, ch_fnd_com, ch_fnd, ch_led, ch_tx, ch_tx_busy,
        input  enable, fnd_com, fnd, led, tx, active_id, switching
    );

    modport slave (
        input  sw, ch_fnd_com, ch_fnd, ch_led, ch_tx, ch_tx_busy,
        output enable, fnd_com, fnd, led, tx, active_id, switching
    );

endinterface

// File: rtl/app_switch_ctrl_req_debounce.sv
// rtl/app_switch_ctrl_req_debounce.sv - switch synchronizer, priority decode and stability counter
module req_debounce
    import app_switch_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int STABLE_CYC = 1_000_000,
    parameter int ID_W       = id_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_i,
    output logic            req_valid_o,
    output logic            req_stable_o,
    output logic [ID_W-1:0] req_id_o
);

    localparam int              CNT_W    = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [ID_W-1:0]  NONE     = ID_W'(id_none(N_CH));

    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [ID_W-1:0]  dec;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid;

    always_comb begin
        dec = NONE;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sync2_q[i]) dec = ID_W'(i);
        end
    end

    // cnt_q is the run length of id_q so far; the pulse fires on the cycle the run reaches STABLE_CYC
    always_comb begin
        id_d  = dec;
        cnt_d = cnt_q;
        valid = 1'b0;
        if (dec != id_q) begin
            cnt_d = CNT_W'(1);
            valid = (STABLE_CYC == 1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
            valid = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            id_q    <= NONE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_valid_o  = valid;
    assign req_stable_o = valid || ((dec == id_q) && (cnt_q == CNT_MAX));
    assign req_id_o     = dec;

endmodule

// File: rtl/app_switch_ctrl.sv
// rtl/app_switch_ctrl.sv - hands display/LED/UART ownership between channels with drain and blanking
module app_switch_ctrl
    import app_switch_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int LED_W      = 5,
    parameter int STABLE_CYC = 1_000_000,
    parameter int BLANK_CYC  = 100_000,
    parameter int DRAIN_MAX  = 2_000_000
) (
    input logic               clk,
    input logic               rst,
    app_switch_ctrl_if.slave  bus
);

    localparam int               ID_W       = id_width(N_CH);
    localparam int               CNT_W      = $clog2(max_int(BLANK_CYC, DRAIN_MAX) + 1);
    localparam logic [ID_W-1:0]  NONE       = ID_W'(id_none(N_CH));
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  active_q, active_d;
    logic [ID_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             recheck_q, recheck_d;

    logic             req_valid, req_stable, accept;
    logic [ID_W-1:0]  req_id;
    logic             old_busy, old_tx;

    logic [N_CH-1:0]  enable;
    logic [3:0]       fnd_com;
    logic [7:0]       fnd;
    logic [LED_W-1:0] led;
    logic             tx;

    req_debounce #(
        .N_CH       (N_CH),
        .STABLE_CYC (STABLE_CYC),
        .ID_W       (ID_W)
    ) u_req_debounce (
        .clk          (clk),
        .rst          (rst),
        .sw_i         (bus.sw),
        .req_valid_o  (req_valid),
        .req_stable_o (req_stable),
        .req_id_o     (req_id)
    );

    // A request that settled while the target was frozen is picked up on the first cycle back
    assign accept = req_valid || (recheck_q && req_stable);

    always_comb begin
        old_busy = 1'b0;
        old_tx   = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (active_q == ID_W'(i)) begin
                old_busy = bus.ch_tx_busy[i];
                old_tx   = bus.ch_tx[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        recheck_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (req_id != NONE)) begin
                    target_d = req_id;
                    cnt_d    = '0;
                    state_d  = ST_BLANK;
                end
            end
            ST_ACTIVE: begin
                if (accept && (req_id != active_q)) begin
                    target_d = req_id;
                    cnt_d    = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((!old_busy && old_tx) || (cnt_q == DRAIN_LAST)) begin
                    active_d = NONE;
                    cnt_d    = '0;
                    state_d  = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    active_d  = target_q;
                    cnt_d     = '0;
                    recheck_d = 1'b1;
                    state_d   = (target_q == NONE) ? ST_IDLE : ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            active_q  <= NONE;
            target_q  <= NONE;
            cnt_q     <= '0;
            recheck_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            recheck_q <= recheck_d;
        end
    end

    // The outgoing channel keeps running through DRAIN so it can finish its UART frame
    always_comb begin
        enable  = '0;
        fnd_com = BLANK_FND_COM;
        fnd     = BLANK_FND;
        led     = '0;
        tx      = BLANK_TX;
        for (int i = 0; i < N_CH; i++) begin
            if (active_q == ID_W'(i)) begin
                enable[i] = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
                if (state_q == ST_ACTIVE) begin
                    fnd_com = bus.ch_fnd_com[4*i +: 4];
                    fnd     = bus.ch_fnd[8*i +: 8];
                    led     = bus.ch_led[LED_W*i +: LED_W];
                    tx      = bus.ch_tx[i];
                end
            end
        end
    end

    assign bus.enable    = enable;
    assign bus.fnd_com   = fnd_com;
    assign bus.fnd       = fnd;
    assign bus.led       = led;
    assign bus.tx        = tx;
    assign bus.active_id = active_q;
    assign bus.switching = (state_q == ST_DRAIN) || (state_q == ST_BLANK);

endmodule

// File: tb/tb_app_switch_ctrl.sv
// tb/tb_app_switch_ctrl.sv - directed self-checking bench for app_switch_ctrl
module tb_app_switch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    app_switch_ctrl_if #(.N_CH(3), .LED_W(5)) bus ();

    app_switch_ctrl #(
        .N_CH       (3),
        .LED_W      (5),
        .STABLE_CYC (3),
        .BLANK_CYC  (4),
        .DRAIN_MAX  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [23:0] pack(input logic [1:0] id, input logic [2:0] en,
                                         input logic [3:0] fc, input logic [7:0] f,
                                         input logic [4:0] l, input logic t, input logic s);
        return {s, t, l, fc, f, en, id};
    endfunction

    function automatic logic [23:0] observed();
        return {bus.switching, bus.tx, bus.led, bus.fnd_com, bus.fnd, bus.enable, bus.active_id};
    endfunction

    task automatic check(input string tag, input logic [23:0] exp);
        logic [23:0] obs;
        obs = observed();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [23:0] idle_v, blank_v, act0_v, act1_v, act2_v, drain0_v, drain1_v, drain2_v;

    initial begin
        idle_v   = pack(2'd3, 3'b000, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b0);
        blank_v  = pack(2'd3, 3'b000, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b1);
        act0_v   = pack(2'd0, 3'b001, 4'hE, 8'h5A, 5'h1F, 1'b1, 1'b0);
        act1_v   = pack(2'd1, 3'b010, 4'hB, 8'hA5, 5'h0A, 1'b1, 1'b0);
        act2_v   = pack(2'd2, 3'b100, 4'h7, 8'hC3, 5'h15, 1'b1, 1'b0);
        drain0_v = pack(2'd0, 3'b001, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b1);
        drain1_v = pack(2'd1, 3'b010, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b1);
        drain2_v = pack(2'd2, 3'b100, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b1);

        bus.sw         = 3'b000;
        bus.ch_fnd_com = {4'h7, 4'hB, 4'hE};
        bus.ch_fnd     = {8'hC3, 8'hA5, 8'h5A};
        bus.ch_led     = {5'h15, 5'h0A, 5'h1F};
        bus.ch_tx      = 3'b111;
        bus.ch_tx_busy = 3'b000;

        step(3);
        check("reset_state", idle_v);
        rst = 1'b0;

        // first selection: 2 sync + 3 stable cycles into BLANK, then 4 blank cycles
        bus.sw = 3'b010;
        step(4);
        check("sel1_still_idle", idle_v);
        step(1);
        check("sel1_blank_enter", blank_v);
        step(3);
        check("sel1_blank_last", blank_v);
        step(1);
        check("sel1_active", act1_v);

        bus.ch_tx = 3'b101;
        step(1);
        check("tx_mux_ch1_low", pack(2'd1, 3'b010, 4'hB, 8'hA5, 5'h0A, 1'b0, 1'b0));
        bus.ch_tx = 3'b111;

        // two-cycle glitch must not survive the stability filter
        bus.sw = 3'b001;
        step(2);
        bus.sw = 3'b010;
        step(10);
        check("glitch_ignored", act1_v);

        // switch to ch2 while ch1 is still transmitting
        bus.ch_tx_busy = 3'b010;
        bus.sw = 3'b100;
        step(5);
        check("drain_busy_enter", drain1_v);
        step(5);
        check("drain_busy_hold", drain1_v);
        bus.ch_tx_busy = 3'b000;
        step(1);
        check("drain_release_blank", blank_v);
        step(3);
        check("blank_to_ch2_last", blank_v);
        step(1);
        check("active_ch2", act2_v);

        // all switches set: lowest index wins; ch2 idle so DRAIN lasts one cycle
        bus.sw = 3'b111;
        step(5);
        check("prio_drain", drain2_v);
        step(1);
        check("prio_blank", blank_v);
        step(4);
        check("prio_active_ch0", act0_v);

        // stuck busy: forced exit after 16 drain cycles
        bus.ch_tx_busy = 3'b001;
        bus.sw = 3'b010;
        step(5);
        check("forced_drain_enter", drain0_v);
        step(15);
        check("forced_drain_cycle16", drain0_v);
        step(1);
        check("forced_drain_exit", blank_v);
        step(4);
        check("forced_active_ch1", act1_v);
        bus.ch_tx_busy = 3'b000;

        // all switches off: back to IDLE through DRAIN and BLANK
        bus.sw = 3'b000;
        step(5);
        check("off_drain", drain1_v);
        step(1);
        check("off_blank", blank_v);
        step(4);
        check("off_idle", idle_v);

        // reset in the middle of BLANK
        bus.sw = 3'b100;
        step(5);
        check("rst_pre_blank", blank_v);
        step(2);
        rst = 1'b1;
        #1;
        check("rst_mid_blank_async", idle_v);
        step(1);
        check("rst_mid_blank_held", idle_v);
        rst = 1'b0;
        step(8);
        check("post_rst_blank", blank_v);
        step(1);
        check("post_rst_active_ch2", act2_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/app_switch_ctrl.md
APP_SWITCH_CTRL -- requirements
Module: app_switch_ctrl

Interface
REQ-001 Parameter N_CH, default 3: number of application channels (2..8).
REQ-002 Parameter LED_W, default 5: LED bus width per channel.
REQ-003 Parameter STABLE_CYC, default 1_000_000: cycles a switch request must hold before acceptance.
REQ-004 Parameter BLANK_CYC, default 100_000: display/tx blanking cycles between channels.
REQ-005 Parameter DRAIN_MAX, default 2_000_000: maximum cycles waiting for the outgoing channel's UART to go idle.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 sw  in  N_CH  raw mode switches; asynchronous to clk.
REQ-009 ch_fnd_com  in  4*N_CH  per-channel digit commons, channel i at [4i+3:4i], active low.
REQ-010 ch_fnd  in  8*N_CH  per-channel segment data, active low.
REQ-011 ch_led  in  LED_W*N_CH  per-channel LED data.
REQ-012 ch_tx  in  N_CH  per-channel UART tx line.
REQ-013 ch_tx_busy  in  N_CH  per-channel UART transmitter busy.
REQ-014 enable  out  N_CH  one-hot (or zero) channel run enable.
REQ-015 fnd_com  out  4  muxed digit commons.
REQ-016 fnd  out  8  muxed segments.
REQ-017 led  out  LED_W  muxed LEDs.
REQ-018 tx  out  1  muxed UART tx.
REQ-019 active_id  out  $clog2(N_CH+1)  current owner; value N_CH = NONE.
REQ-020 switching  out  1  high in DRAIN and BLANK states.

Function
REQ-021 sw SHALL pass through a 2-flop synchronizer before any use.
REQ-022 Request decode: lowest-index set bit of synchronized sw; no bit set = NONE.
REQ-023 Decoded request accepted only after unchanged for STABLE_CYC consecutive cycles; any change restarts the stability counter.
REQ-024 FSM states: IDLE, ACTIVE, DRAIN, BLANK.
REQ-025 IDLE: active_id = NONE; accepted request R != NONE -> latch target = R, go BLANK.
REQ-026 ACTIVE: accepted request R != active_id -> latch target = R, go DRAIN; R == active_id is ignored.
REQ-027 DRAIN: enable keeps the old channel asserted; exit to BLANK when ch_tx_busy[old] == 0 and ch_tx[old] == 1, or after DRAIN_MAX cycles (forced).
REQ-028 BLANK: all enable = 0; after BLANK_CYC cycles -> ACTIVE with active_id = target, or IDLE if target == NONE.
REQ-029 Target is frozen during DRAIN/BLANK; request changes there are evaluated only after re-entering ACTIVE/IDLE, with the stability counter still running.
REQ-030 ACTIVE outputs: enable = 1 << active_id; fnd_com, fnd, led, tx = channel active_id inputs, combinationally muxed.
REQ-031 Blanked outputs (IDLE, DRAIN, BLANK): fnd_com = 4'hF, fnd = 8'hFF, led = 0, tx = 1.
REQ-032 enable SHALL never have more than one bit set.
REQ-033 Counters saturate, never wrap; width = $clog2(max parameter + 1).

Reset
REQ-034 On rst: state IDLE, active_id = NONE, target = NONE, enable = 0, counters = 0, synchronizer = 0, outputs at blanked values (REQ-031).
REQ-035 Reset mid-DRAIN/BLANK aborts the switch immediately, with no partial enable.

Structure
REQ-036 Package app_switch_pkg holds the state enum and the NONE/blank output constants.
REQ-037 One sub-module, req_debounce (synchronizer, priority decode, stability counter), outputs req_valid pulse plus req_id.

Verification (N_CH=3, STABLE_CYC=3, BLANK_CYC=4, DRAIN_MAX=16)
REQ-038 Reset, then sw=3'b010 held -> after 2 sync + 3 stable + 4 blank cycles, active_id=1, enable=3'b010, fnd mirrors channel 1.
REQ-039 Active ch1, sw=3'b100 with ch_tx_busy[1]=1 for 10 cycles -> DRAIN holds, enable=3'b010, tx=1, fnd=8'hFF; then BLANK 4 cycles, active_id=2.
REQ-040 DRAIN with ch_tx_busy[old] stuck at 1 -> forced exit after 16 cycles, then BLANK.
REQ-041 sw glitch 3'b001 for 2 cycles, then back -> no switch, active_id unchanged.
REQ-042 sw=3'b111 -> channel 0 selected; sw=0 -> DRAIN, BLANK, IDLE with active_id=3, all enable=0.
REQ-043 rst asserted mid-BLANK -> next edge IDLE, blanked outputs, enable=0.
